axi_lite_slave_mem: RTL and testbench

AXI4-Lite slave memory that terminates the transactions issued by `axi_lite_dut` (the AXI4-Lite master) on the testbench side. It holds a small word-addressed register array, accepts write address/data independently in any order, returns write responses and read data with fixed latency, and flags out-of-range accesses with SLVERR. It sits directly downstream of the master on the AXI bus and gives the scoreboard a deterministic, checkable target.

---
 rtl/axi_lite_slave_mem_if.sv | 33 +++
 rtl/axi_lite_slave_mem.sv | 187 ++++++++++++++++++
 tb/tb_axi_lite_slave_mem.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_slave_mem_if.sv
// AXI4-Lite bus bundle between a master and the slave memory; all five channels, no clock/reset.
interface axi_lite_slave_mem_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave word memory: bvalid one edge after AW+W complete, rvalid one edge after AR.
// One write and one read outstanding; readies drop while a response waits on bready/rready.
module axi_lite_slave_mem #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DEPTH      = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input logic                 aclk,
   input logic                 areset,
   axi_lite_slave_mem_if.slave s_axi
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int IW = $clog2(DEPTH);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t                r_wstate;
   r_state_t                r_rstate;
   logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

   logic                    r_awready;
   logic                    r_wready;
   logic                    r_bvalid;
   logic [1:0]              r_bresp;
   logic                    r_aw_got;
   logic                    r_w_got;
   logic [ADDR_WIDTH-1:2]   r_awaddr;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [NB-1:0]           r_wstrb;

   logic                    r_arready;
   logic                    r_rvalid;
   logic [DATA_WIDTH-1:0]   r_rdata;
   logic [1:0]              r_rresp;

   logic                    w_aw_hs;
   logic                    w_w_hs;
   logic                    w_ar_hs;
   logic                    w_aw_ok;
   logic                    w_w_ok;
   logic                    w_commit;
   logic                    w_we;
   logic [ADDR_WIDTH-1:2]   w_awaddr;
   logic [DATA_WIDTH-1:0]   w_wdata;
   logic [NB-1:0]           w_wstrb;
   logic                    w_wr_in;
   logic [IW-1:0]           w_wr_idx;
   logic                    w_rd_in;
   logic [IW-1:0]           w_rd_idx;
   logic [DATA_WIDTH-1:0]   w_merge;

   assign w_aw_hs  = s_axi.awvalid & r_awready;
   assign w_w_hs   = s_axi.wvalid  & r_wready;
   assign w_ar_hs  = s_axi.arvalid & r_arready;
   assign w_aw_ok  = r_aw_got | w_aw_hs;
   assign w_w_ok   = r_w_got  | w_w_hs;
   assign w_commit = (r_wstate == W_IDLE) & w_aw_ok & w_w_ok;
   assign w_we     = w_commit & w_wr_in;

   // A half captured earlier comes from the holding registers, the other half straight off the bus.
   assign w_awaddr = r_aw_got ? r_awaddr : s_axi.awaddr[ADDR_WIDTH-1:2];
   assign w_wdata  = r_w_got  ? r_wdata  : s_axi.wdata;
   assign w_wstrb  = r_w_got  ? r_wstrb  : s_axi.wstrb;

   // BASE_ADDR is aligned to the window size, so range check is an upper-bit match.
   assign w_wr_in  = (w_awaddr[ADDR_WIDTH-1:IW+2] == BASE_ADDR[ADDR_WIDTH-1:IW+2]);
   assign w_wr_idx = w_awaddr[IW+1:2];
   assign w_rd_in  = (s_axi.araddr[ADDR_WIDTH-1:IW+2] == BASE_ADDR[ADDR_WIDTH-1:IW+2]);
   assign w_rd_idx = s_axi.araddr[IW+1:2];

   always_comb begin
      w_merge = r_mem[w_wr_idx];
      for (int b = 0; b < NB; b++) begin
         if (w_wstrb[b]) begin
            w_merge[8*b +: 8] = w_wdata[8*b +: 8];
         end
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_word
      always_ff @(posedge aclk or posedge areset) begin
         if (areset) begin
            r_mem[g] <= '0;
         end else if (w_we && (w_wr_idx == IW'(g))) begin
            r_mem[g] <= w_merge;
         end
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_wstate  <= W_IDLE;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
         r_aw_got  <= 1'b0;
         r_w_got   <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
      end else begin
         case (r_wstate)
            W_IDLE: begin
               if (w_commit) begin
                  r_bresp   <= w_wr_in ? RESP_OKAY : RESP_SLVERR;
                  r_bvalid  <= 1'b1;
                  r_awready <= 1'b0;
                  r_wready  <= 1'b0;
                  r_aw_got  <= 1'b0;
                  r_w_got   <= 1'b0;
                  r_wstate  <= W_RESP;
               end else begin
                  if (w_aw_hs) begin
                     r_aw_got <= 1'b1;
                     r_awaddr <= s_axi.awaddr[ADDR_WIDTH-1:2];
                  end
                  if (w_w_hs) begin
                     r_w_got <= 1'b1;
                     r_wdata <= s_axi.wdata;
                     r_wstrb <= s_axi.wstrb;
                  end
                  // Also raises the readies on the first edge out of reset.
                  r_awready <= ~w_aw_ok;
                  r_wready  <= ~w_w_ok;
               end
            end
            W_RESP: begin
               if (s_axi.bready) begin
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_wready  <= 1'b1;
                  r_wstate  <= W_IDLE;
               end
            end
            default: r_wstate <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_rstate  <= R_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= RESP_OKAY;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               if (w_ar_hs) begin
                  // r_mem still holds pre-write contents on a same-edge write.
                  r_rdata   <= w_rd_in ? r_mem[w_rd_idx] : '0;
                  r_rresp   <= w_rd_in ? RESP_OKAY : RESP_SLVERR;
                  r_rvalid  <= 1'b1;
                  r_arready <= 1'b0;
                  r_rstate  <= R_DATA;
               end else begin
                  r_arready <= 1'b1;
               end
            end
            R_DATA: begin
               if (s_axi.rready) begin
                  r_rvalid  <= 1'b0;
                  r_arready <= 1'b1;
                  r_rstate  <= R_IDLE;
               end
            end
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

   assign s_axi.awready = r_awready;
   assign s_axi.wready  = r_wready;
   assign s_axi.bvalid  = r_bvalid;
   assign s_axi.bresp   = r_bresp;
   assign s_axi.arready = r_arready;
   assign s_axi.rvalid  = r_rvalid;
   assign s_axi.rdata   = r_rdata;
   assign s_axi.rresp   = r_rresp;
endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Bench for axi_lite_slave_mem: directed transactions with literal expectations, then random
// traffic checked every cycle against a queue-based transaction model of the memory.
module tb_axi_lite_slave_mem;
   localparam int          DW    = 32;
   localparam int          AW    = 32;
   localparam int          DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic aclk   = 1'b0;
   logic areset = 1'b1;
   always #5 aclk = ~aclk;

   axi_lite_slave_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   axi_lite_slave_mem #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE)
   ) dut (
      .aclk(aclk), .areset(areset), .s_axi(bus)
   );

   int n_chk = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_chk++;
      n_bad++;
      $display("FAIL timeout %s at %0t", name, $time);
   endtask

   // ---------------- transaction-level model ----------------
   typedef struct packed {logic [31:0] d; logic [3:0] s;} wbeat_t;
   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_awq [$];
   wbeat_t      m_wq  [$];
   bit          m_live, m_bv, m_rv;
   logic [1:0]  m_bresp, m_rresp;
   logic [31:0] m_rdata;

   function automatic bit in_rng(input logic [31:0] a);
      return ({32'b0, a} >= {32'b0, BASE}) && ({32'b0, a} < ({32'b0, BASE} + 64'(DEPTH * 4)));
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   function automatic bit exp_awready();
      return m_live && !m_bv && (m_awq.size() == 0);
   endfunction
   function automatic bit exp_wready();
      return m_live && !m_bv && (m_wq.size() == 0);
   endfunction
   function automatic bit exp_arready();
      return m_live && !m_rv;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_awq.delete();
      m_wq.delete();
      m_live = 0; m_bv = 0; m_rv = 0;
      m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
   endtask

   task automatic model_step();
      bit aw_f, w_f, ar_f, b_f, r_f;
      logic [31:0] a;
      wbeat_t      wb;
      aw_f = bus.awvalid && exp_awready();
      w_f  = bus.wvalid  && exp_wready();
      ar_f = bus.arvalid && exp_arready();
      b_f  = m_bv && bus.bready;
      r_f  = m_rv && bus.rready;
      if (r_f) m_rv = 0;
      if (ar_f) begin
         m_rv = 1;
         if (in_rng(bus.araddr)) begin
            m_rdata = m_mem[widx(bus.araddr)];
            m_rresp = 2'b00;
         end else begin
            m_rdata = '0;
            m_rresp = 2'b10;
         end
      end
      if (b_f) m_bv = 0;
      if (aw_f) m_awq.push_back(bus.awaddr);
      if (w_f)  m_wq.push_back({bus.wdata, bus.wstrb});
      if (m_awq.size() > 0 && m_wq.size() > 0) begin
         a  = m_awq.pop_front();
         wb = m_wq.pop_front();
         if (in_rng(a)) begin
            for (int b = 0; b < 4; b++)
               if (wb.s[b]) m_mem[widx(a)][8*b +: 8] = wb.d[8*b +: 8];
            m_bresp = 2'b00;
         end else begin
            m_bresp = 2'b10;
         end
         m_bv = 1;
      end
      m_live = 1;
   endtask

   task automatic compare();
      chk("awready", bus.awready, exp_awready());
      chk("wready",  bus.wready,  exp_wready());
      chk("arready", bus.arready, exp_arready());
      chk("bvalid",  bus.bvalid,  m_bv);
      chk("rvalid",  bus.rvalid,  m_rv);
      if (m_bv) chk("bresp", bus.bresp, m_bresp);
      if (m_rv) begin
         chk("rdata", bus.rdata, m_rdata);
         chk("rresp", bus.rresp, m_rresp);
      end
   endtask

   always @(posedge aclk) begin
      if (areset) begin
         model_reset();
      end else begin
         model_step();
         #1;
         if (chk_en) compare();
      end
   end

   always @(posedge areset) model_reset();

   // ---------------- driver ----------------
   task automatic idle_inputs();
      bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
      bus.bready = 1; bus.araddr = '0; bus.arvalid = 0; bus.rready = 1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " awready"}, bus.awready, 0);
      chk({tag, " wready"},  bus.wready,  0);
      chk({tag, " arready"}, bus.arready, 0);
      chk({tag, " bvalid"},  bus.bvalid,  0);
      chk({tag, " rvalid"},  bus.rvalid,  0);
      chk({tag, " bresp"},   bus.bresp,   0);
      chk({tag, " rresp"},   bus.rresp,   0);
      chk({tag, " rdata"},   bus.rdata,   0);
   endtask

   // Called right after a negedge; returns idle cycles between acceptance and bvalid.
   task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output int lat);
      bit fa, fw;
      int t;
      bus.awaddr = a; bus.awvalid = 1; bus.wdata = d; bus.wstrb = s; bus.wvalid = 1;
      bus.bready = 1;
      t = 0;
      while (bus.awvalid || bus.wvalid) begin
         fa = bus.awvalid && bus.awready;
         fw = bus.wvalid && bus.wready;
         @(negedge aclk);
         if (fa) bus.awvalid = 0;
         if (fw) bus.wvalid = 0;
         if (++t > 20) begin
            timeout("write accept");
            bus.awvalid = 0; bus.wvalid = 0;
         end
      end
      resp = 2'bxx;
      lat = 0;
      while (!bus.bvalid && lat < 20) begin
         @(negedge aclk);
         lat++;
      end
      if (!bus.bvalid) timeout("bvalid");
      else begin
         resp = bus.bresp;
         @(negedge aclk);
      end
   endtask

   task automatic read_txn(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                           output int lat);
      bit fr;
      int t;
      bus.araddr = a; bus.arvalid = 1; bus.rready = 1;
      t = 0;
      while (bus.arvalid) begin
         fr = bus.arready;
         @(negedge aclk);
         if (fr) bus.arvalid = 0;
         if (++t > 20) begin
            timeout("read accept");
            bus.arvalid = 0;
         end
      end
      d = 'x; resp = 2'bxx;
      lat = 0;
      while (!bus.rvalid && lat < 20) begin
         @(negedge aclk);
         lat++;
      end
      if (!bus.rvalid) timeout("rvalid");
      else begin
         d = bus.rdata;
         resp = bus.rresp;
         @(negedge aclk);
      end
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 9))
         0:       return 32'($urandom);
         1:       return 32'h40 + 32'($urandom_range(0, 15) << 2);
         default: return BASE + 32'($urandom_range(0, DEPTH - 1) << 2) + 32'($urandom_range(0, 3));
      endcase
   endfunction

   logic [31:0] rd;
   logic [1:0]  rsp;
   int          lat;
   bit          fa, fw, far;

   initial begin
      idle_inputs();
      areset = 1;
      repeat (2) @(negedge aclk);
      chk_all_zero("in reset");
      areset = 0;
      chk_en = 1;
      @(negedge aclk);
      chk("post-reset awready", bus.awready, 1);
      chk("post-reset wready",  bus.wready,  1);
      chk("post-reset arready", bus.arready, 1);
      chk("post-reset bvalid",  bus.bvalid,  0);
      chk("post-reset rvalid",  bus.rvalid,  0);

      // write then read
      write_txn(32'h04, 32'hDEADBEEF, 4'hF, rsp, lat);
      chk("wr04 bresp", rsp, 2'b00);
      chk("wr04 latency", lat, 0);
      read_txn(32'h04, rd, rsp, lat);
      chk("rd04 data", rd, 32'hDEADBEEF);
      chk("rd04 rresp", rsp, 2'b00);
      chk("rd04 latency", lat, 0);

      // W three cycles ahead of AW, partial strobes
      bus.wdata = 32'h11223344; bus.wstrb = 4'h5; bus.wvalid = 1;
      @(negedge aclk);
      bus.wvalid = 0;
      chk("split wready", bus.wready, 0);
      chk("split awready", bus.awready, 1);
      chk("split early bvalid", bus.bvalid, 0);
      repeat (2) begin
         @(negedge aclk);
         chk("split wait bvalid", bus.bvalid, 0);
         chk("split wait awready", bus.awready, 1);
      end
      bus.awaddr = 32'h08; bus.awvalid = 1;
      @(negedge aclk);
      bus.awvalid = 0;
      chk("split bvalid", bus.bvalid, 1);
      chk("split bresp", bus.bresp, 2'b00);
      @(negedge aclk);
      chk("split bvalid drop", bus.bvalid, 0);
      chk("split awready back", bus.awready, 1);
      chk("split wready back", bus.wready, 1);
      read_txn(32'h08, rd, rsp, lat);
      chk("rd08 merged", rd, 32'h00220044);

      // out of range
      write_txn(32'h40, 32'hFFFFFFFF, 4'hF, rsp, lat);
      chk("wr40 bresp", rsp, 2'b10);
      read_txn(32'h40, rd, rsp, lat);
      chk("rd40 data", rd, 32'h0);
      chk("rd40 rresp", rsp, 2'b10);
      read_txn(32'h00, rd, rsp, lat);
      chk("rd00 untouched", rd, 32'h0);
      read_txn(32'h04, rd, rsp, lat);
      chk("rd04 untouched", rd, 32'hDEADBEEF);

      // backpressure on both response channels
      bus.bready = 0; bus.rready = 0;
      bus.awaddr = 32'h0C; bus.awvalid = 1; bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF;
      bus.wvalid = 1; bus.araddr = 32'h04; bus.arvalid = 1;
      @(negedge aclk);
      bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
      repeat (5) begin
         chk("bp bvalid", bus.bvalid, 1);
         chk("bp bresp", bus.bresp, 2'b00);
         chk("bp rvalid", bus.rvalid, 1);
         chk("bp rdata", bus.rdata, 32'hDEADBEEF);
         chk("bp rresp", bus.rresp, 2'b00);
         chk("bp awready", bus.awready, 0);
         chk("bp wready", bus.wready, 0);
         chk("bp arready", bus.arready, 0);
         @(negedge aclk);
      end
      bus.bready = 1; bus.rready = 1;
      @(negedge aclk);
      chk("bp release bvalid", bus.bvalid, 0);
      chk("bp release rvalid", bus.rvalid, 0);
      chk("bp release awready", bus.awready, 1);
      chk("bp release wready", bus.wready, 1);
      chk("bp release arready", bus.arready, 1);
      read_txn(32'h0C, rd, rsp, lat);
      chk("rd0C data", rd, 32'hCAFEF00D);

      // reset with AW captured and W outstanding
      bus.awaddr = 32'h04; bus.awvalid = 1;
      @(negedge aclk);
      bus.awvalid = 0;
      chk("midop awready", bus.awready, 0);
      chk("midop wready", bus.wready, 1);
      #2 areset = 1;
      #1 chk_all_zero("async reset");
      @(negedge aclk);
      areset = 0;
      repeat (4) begin
         @(negedge aclk);
         chk("after reset bvalid", bus.bvalid, 0);
      end
      read_txn(32'h04, rd, rsp, lat);
      chk("rd04 cleared", rd, 32'h0);
      read_txn(32'h0C, rd, rsp, lat);
      chk("rd0C cleared", rd, 32'h0);

      // random traffic; valids held until accepted
      for (int c = 0; c < 2000; c++) begin
         fa  = bus.awvalid && bus.awready;
         fw  = bus.wvalid && bus.wready;
         far = bus.arvalid && bus.arready;
         @(negedge aclk);
         if (!bus.awvalid || fa) begin
            bus.awvalid = ($urandom_range(0, 2) == 0);
            bus.awaddr  = rand_addr();
         end
         if (!bus.wvalid || fw) begin
            bus.wvalid = ($urandom_range(0, 2) == 0);
            bus.wdata  = 32'($urandom);
            bus.wstrb  = 4'($urandom_range(0, 15));
         end
         if (!bus.arvalid || far) begin
            bus.arvalid = ($urandom_range(0, 1) == 0);
            bus.araddr  = rand_addr();
         end
         bus.bready = ($urandom_range(0, 3) != 0);
         bus.rready = ($urandom_range(0, 3) != 0);
      end
      idle_inputs();
      repeat (5) @(negedge aclk);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
